// File: rtl/alu_shift_pkg.sv
// Shared ALU shift definitions: widths, normalize modes,
// FSM states and shifter aluc encodings.
package alu_shift_pkg;
  localparam int WIDTH = 32;
  localparam int SHW   = $clog2(WIDTH) + 1;

  localparam logic NORM_LEFT  = 1'b0;
  localparam logic NORM_RIGHT = 1'b1;

  typedef enum logic {
    IDLE,
    SEARCH
  } state_t;

  localparam logic [1:0] ALUC_SRA  = 2'b00;
  localparam logic [1:0] ALUC_SLL  = 2'b01;
  localparam logic [1:0] ALUC_SRL  = 2'b10;
  localparam logic [1:0] ALUC_SLL2 = 2'b11;
endpackage

// File: rtl/norm_step.sv
// One binary-search step: shift work by k toward the
// chosen edge when the k bits at that edge are all zero.
module norm_step
  import alu_shift_pkg::*;
(
  input  logic [WIDTH-1:0] work,
  input  logic [SHW-1:0]   k,
  input  logic             mode,
  output logic [WIDTH-1:0] work_nx,
  output logic             hit
);
  localparam logic [WIDTH-1:0] ONES = '1;

  always_comb begin
    hit     = 1'b0;
    work_nx = work;
    unique case (1'b1)
      (mode == NORM_LEFT): begin
        hit = (work & ~(ONES >> k)) == '0;
        if (hit) work_nx = work << k;
      end
      (mode == NORM_RIGHT): begin
        hit = (work & ~(ONES << k)) == '0;
        if (hit) work_nx = work >> k;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/shift_normalizer32.sv
// Multi-cycle normalizer: fixed 5-step binary search for
// the leading/trailing one, with zero-operand override.
module shift_normalizer32
  import alu_shift_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] norm,
  output logic [SHW-1:0]   shamt,
  output logic             zero
);
  localparam logic [SHW-1:0] K0   = SHW'(WIDTH / 2);
  localparam logic [2:0]     LAST = 3'($clog2(WIDTH) - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_nx;
  logic [SHW-1:0]   acc_q, acc_nx, k;
  logic [2:0]       step_q;
  logic             mode_q, op_zero, hit, last;

  assign k      = K0 >> step_q;
  assign acc_nx = acc_q + (hit ? k : '0);
  assign busy   = (state_q == SEARCH);

  norm_step u_step (
    .work    (work_q),
    .k       (k),
    .mode    (mode_q),
    .work_nx (work_nx),
    .hit     (hit)
  );

  always_comb begin
    state_d = state_q;
    last    = 1'b0;
    case (state_q)
      IDLE:
        if (start) state_d = SEARCH;
      SEARCH:
        if (step_q == LAST) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q  <= '0;
      acc_q   <= '0;
      step_q  <= '0;
      mode_q  <= NORM_LEFT;
      op_zero <= 1'b0;
      done    <= 1'b0;
      norm    <= '0;
      shamt   <= '0;
      zero    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          work_q  <= a;
          mode_q  <= mode;
          acc_q   <= '0;
          step_q  <= '0;
          op_zero <= (a == '0);
        end
      end else begin
        work_q <= work_nx;
        acc_q  <= acc_nx;
        step_q <= step_q + 3'd1;
        if (last) begin
          // all-zero operand never finds a one; report WIDTH
          done   <= 1'b1;
          norm   <= op_zero ? '0 : work_nx;
          shamt  <= op_zero ? SHW'(WIDTH) : acc_nx;
          zero   <= op_zero;
          step_q <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_shift_normalizer32.sv
// Self-checking bench for shift_normalizer32: directed
// cases plus randomized traffic against a clz/ctz model.
module tb_shift_normalizer32;
  import alu_shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] a = '0;
  logic        busy, done, zero;
  logic [31:0] norm;
  logic [5:0]  shamt;

  int errs = 0;
  int checks = 0;
  int nprint = 0;

  shift_normalizer32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .a     (a),
    .busy  (busy),
    .done  (done),
    .norm  (norm),
    .shamt (shamt),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      if (nprint < 40) begin
        nprint++;
        $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp,
                 $time);
      end
    end
  endtask

  // reference: count zeros from the chosen edge bit by bit
  function automatic void ref_calc(input logic md,
                                   input logic [31:0] op,
                                   output logic [31:0] n,
                                   output logic [5:0] s);
    int c;
    c = 0;
    if (op == 0) begin
      n = '0;
      s = 6'd32;
      return;
    end
    if (md == NORM_LEFT) begin
      while (op[31-c] == 1'b0) c++;
      n = op << c;
    end else begin
      while (op[c] == 1'b0) c++;
      n = op >> c;
    end
    s = 6'(c);
  endfunction

  int          m_cnt = 0;
  logic        m_done = 0, m_zero = 0, m_mode = 0;
  logic [31:0] m_norm = '0, m_a = '0, p_norm = '0;
  logic [5:0]  m_shamt = '0, p_sh = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   = 0;
      m_done  = 0;
      m_norm  = '0;
      m_shamt = '0;
      m_zero  = 0;
    end else begin
      m_done = 0;
      if (m_cnt == 0) begin
        if (start) begin
          m_cnt  = 5;
          m_a    = a;
          m_mode = mode;
          ref_calc(mode, a, p_norm, p_sh);
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done  = 1;
          m_norm  = p_norm;
          m_shamt = p_sh;
          m_zero  = (m_a == 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_cnt > 0));
    chk("done", 64'(done), 64'(m_done));
    chk("norm", 64'(norm), 64'(m_norm));
    chk("shamt", 64'(shamt), 64'(m_shamt));
    chk("zero", 64'(zero), 64'(m_zero));
    if (done && m_a != 0) begin
      if (m_mode == NORM_LEFT)
        chk("inv_left", 64'(norm >> shamt), 64'(m_a));
      else
        chk("inv_right", 64'(norm << shamt), 64'(m_a));
    end
  end

  task automatic start_pulse(input logic md, input logic [31:0] op);
    start = 1'b1;
    mode  = md;
    a     = op;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    mode  = 1'($urandom);
  endtask

  task automatic wait_done(output int lat, output int bn);
    lat = 1;
    bn  = busy ? 1 : 0;
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
      if (busy) bn++;
    end
    if (!done) chk("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic run(input logic md, input logic [31:0] op,
                     input logic [31:0] en, input logic [5:0] es,
                     input logic ez);
    int lat, bn;
    start_pulse(md, op);
    wait_done(lat, bn);
    chk("latency", 64'(lat - 1), 64'd5);
    chk("busy_cycles", 64'(bn), 64'd5);
    chk("lit_norm", 64'(norm), 64'(en));
    chk("lit_shamt", 64'(shamt), 64'(es));
    chk("lit_zero", 64'(zero), 64'(ez));
    chk("model_norm", 64'(m_norm), 64'(en));
    chk("model_shamt", 64'(m_shamt), 64'(es));
  endtask

  initial begin
    int lat, bn, seen;
    logic [31:0] op;
    int sh;

    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_norm", 64'(norm), 64'd0);
    chk("rst_shamt", 64'(shamt), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run(NORM_LEFT, 32'h0000_00F0, 32'hF000_0000, 6'd24, 1'b0);
    run(NORM_RIGHT, 32'h0000_00F0, 32'h0000_000F, 6'd4, 1'b0);
    run(NORM_LEFT, 32'h0000_0001, 32'h8000_0000, 6'd31, 1'b0);
    run(NORM_LEFT, 32'h0000_0000, 32'h0000_0000, 6'd32, 1'b1);
    run(NORM_RIGHT, 32'h0000_0000, 32'h0000_0000, 6'd32, 1'b1);
    run(NORM_LEFT, 32'h8000_0000, 32'h8000_0000, 6'd0, 1'b0);

    // start while busy is ignored
    start_pulse(NORM_LEFT, 32'h0001_0000);
    start = 1'b1;
    a     = 32'hFFFF_FFFF;
    mode  = NORM_LEFT;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bn);
    chk("ign_shamt", 64'(shamt), 64'd15);
    chk("ign_norm", 64'(norm), 64'h8000_0000);

    // start in the done cycle is accepted
    start_pulse(NORM_RIGHT, 32'h0000_0300);
    wait_done(lat, bn);
    chk("chain_latency", 64'(lat - 1), 64'd5);
    chk("chain_shamt", 64'(shamt), 64'd8);
    chk("chain_norm", 64'(norm), 64'h0000_0003);

    // asynchronous reset at step 2
    start_pulse(NORM_LEFT, 32'h0000_1234);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_norm", 64'(norm), 64'd0);
    chk("arst_shamt", 64'(shamt), 64'd0);
    chk("arst_zero", 64'(zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("no_spurious_done", 64'(seen), 64'd0);
    run(NORM_LEFT, 32'h0000_1234, 32'h91A0_0000, 6'd19, 1'b0);

    // randomized traffic, including starts while busy
    for (int i = 0; i < 12000; i++) begin
      op = $urandom;
      sh = $urandom_range(0, 31);
      mode = 1'($urandom);
      op = (mode == NORM_LEFT) ? (op >> sh) : (op << sh);
      if ($urandom_range(0, 15) == 0) op = '0;
      a = op;
      start = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
